spi_transmitter: RTL and testbench
==================================

// Module: spi_transmitter
// PURPOSE
// - SPI slave transmitter; counterpart of spi_receiver on the same bus. Shifts a bitcount-wide word out on sdo
//   under an external master's ss/sclk, oversampled by the system clock.
// - Word is staged in a single-entry holding register via load/ready; a frame consumes it at ss assertion.
// PARAMETERS
// - bitcount       8  frame length in bits (>=2)
// - ss_polarity    1  active level of ss
// - sclk_polarity  0  sclk idle level; leading edge = transition away from idle
// - sclk_phase     1  0: master samples on leading edge, we shift on trailing; 1: we shift on leading, master samples on trailing
// - msb_first      1  1: data[bitcount-1] first; 0: data[0] first
// PORTS
// - clock     in   1         system clock; >= 8x sclk frequency
// - reset     in   1         synchronous, active-high
// - data      in   bitcount  word to transmit
// - load      in   1         strobe: capture data into holding register
// - ready     out  1         holding register empty
// - ss        in   1         slave select from master (asynchronous)
// - sclk      in   1         serial clock from master (asynchronous)
// - sdo       out  1         serial data out
// - busy      out  1         frame in progress
// - done      out  1         1-cycle pulse: frame completed with bitcount bits
// - underrun  out  1         1-cycle pulse: frame started with empty holding register
// BEHAVIOUR
// - Reset: sdo=0, busy=0, done=0, underrun=0, ready=1; holding register cleared; state IDLE.
// - ss and sclk pass 2-FF synchronizers plus one edge-detect stage; sdo changes 3 clocks after the pin edge.
// - load: hold<=data, ready<=0; load while ready=0 overwrites (last write wins).
// - States IDLE -> ACTIVE -> WAIT_SS -> IDLE.
// - IDLE: on synchronized ss inactive->active edge: shift<=hold (or all zeros if empty, pulse underrun);
//   hold emptied (ready<=1); bit counter<=0; busy<=1; go ACTIVE.
// - load in the same cycle as frame start: the new data is transmitted (bypass); ready stays 1.
// - ss already active at reset release: no frame; a fresh inactive->active edge is required.
// - ACTIVE, sclk_phase=0: first bit on sdo at frame start; next bit on each trailing edge;
//   counter increments on each leading edge.
// - ACTIVE, sclk_phase=1: sdo=0 until first leading edge, then first bit; next bit on each
//   following leading edge; counter increments on each trailing edge.
// - Counter reaches bitcount: done pulses 1 cycle, busy<=0, sdo<=0, go WAIT_SS; further sclk edges ignored.
// - WAIT_SS: on ss deassert go IDLE.
// - ss deasserted in ACTIVE before bitcount bits: abort; no done, busy<=0, sdo<=0, IDLE; word is lost.
// - Synchronous reset mid-frame: immediate return to reset values; in-flight word and hold discarded.
// - Bit order: msb_first=1 shifts left out of MSB; msb_first=0 shifts right out of LSB.
// CONFIGURATION
// - SPI_TRANSMITTER_TRISTATE_EN defined: sdo is 1'bz whenever synchronized ss is inactive
//   (IDLE/after deassert), driven otherwise; allows a shared MISO line.
// - Not defined: sdo always driven; 0 when not transmitting.
// TESTING
// - Defaults; load 8'hA5; master sends 8 clocks -> sdo bits 1,0,1,0,0,1,0,1; done 1 pulse; ready=1.
// - msb_first=0, data 8'h01 -> first bit 1, then seven 0s; done pulses once.
// - No load before ss assert -> underrun pulses at frame start; sdo transmits 8'h00; done still pulses.
// - ss deasserted after 4 sclk cycles -> no done, busy=0, next frame (load 8'h3C) sends 8'h3C intact.
// - sclk_phase=0, sclk_polarity=1, data 8'hC3 -> bit7 valid before first falling sclk; received word 8'hC3.
// - reset pulsed mid-frame with ss held active -> outputs at reset values; no frame until ss toggles.

Source files
------------

// File: rtl/spi_transmitter.sv
// SPI slave transmitter: shifts a staged word out on sdo under an external master's ss/sclk.
// Latency: sdo follows a pin edge of ss/sclk by 3 clocks (2-FF sync + edge-detect + output register).
// Backpressure: none toward the master; ready low = holding register full, a new load overwrites it.
// Optional build macro SPI_TRANSMITTER_TRISTATE_EN: sdo floats (1'bz) while synchronized ss is inactive.
module spi_transmitter #(
    parameter int bitcount      = 8,
    parameter int ss_polarity   = 1,
    parameter int sclk_polarity = 0,
    parameter int sclk_phase    = 1,
    parameter int msb_first     = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [bitcount-1:0] data,
    input  logic                load,
    output logic                ready,
    input  logic                ss,
    input  logic                sclk,
    output logic                sdo,
    output logic                busy,
    output logic                done,
    output logic                underrun
);

    localparam int   CW        = $clog2(bitcount + 1);
    localparam logic SS_ACT    = (ss_polarity != 0);
    localparam logic SCLK_IDLE = (sclk_polarity != 0);
    localparam logic PHASE1    = (sclk_phase != 0);
    localparam logic MSB_FIRST = (msb_first != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_WAIT_SS = 2'd2
    } state_t;

    state_t              state_q;

    // Synchronizer chains: s1/s2 are the 2-FF synchronizer, s3 is the edge-detect history.
    logic                ss_s1_q, ss_s2_q, ss_s3_q;
    logic                sclk_s1_q, sclk_s2_q, sclk_s3_q;

    logic [bitcount-1:0] hold_q;
    logic                ready_q;
    logic [bitcount-1:0] shift_q;
    logic [CW-1:0]       cnt_q;
    logic                sdo_q;
    logic                busy_q;
    logic                done_q;
    logic                underrun_q;

    // Decoded events and next-value helpers
    logic                ss_act_d;
    logic                ss_start_d;
    logic                lead_edge_d;
    logic                trail_edge_d;
    logic                shift_edge_d;
    logic                count_edge_d;
    logic [bitcount-1:0] frame_word_d;
    logic                start_bit_d;
    logic [bitcount-1:0] start_rest_d;
    logic                next_bit_d;
    logic [bitcount-1:0] next_rest_d;
    logic [CW-1:0]       cnt_inc_d;
    logic                last_bit_d;

    // Edge decode of synchronized pins and selection of the word/bit to put on the wire
    always_comb begin
        ss_act_d     = (ss_s2_q == SS_ACT);
        ss_start_d   = ss_act_d && (ss_s3_q != SS_ACT);
        lead_edge_d  = (sclk_s2_q != sclk_s3_q) && (sclk_s3_q == SCLK_IDLE);
        trail_edge_d = (sclk_s2_q != sclk_s3_q) && (sclk_s2_q == SCLK_IDLE);

        // Phase 1 shifts on the leading edge and counts completed bits on the trailing one;
        // phase 0 is the mirror image, with the first bit presented at frame start.
        shift_edge_d = PHASE1 ? lead_edge_d  : trail_edge_d;
        count_edge_d = PHASE1 ? trail_edge_d : lead_edge_d;

        // A load coinciding with frame start wins over the holding register (bypass).
        // An empty holding register is kept at zero, so an underrun frame sends all zeros.
        frame_word_d = load ? data : hold_q;

        if (MSB_FIRST) begin
            start_bit_d  = frame_word_d[bitcount-1];
            start_rest_d = {frame_word_d[bitcount-2:0], 1'b0};
            next_bit_d   = shift_q[bitcount-1];
            next_rest_d  = {shift_q[bitcount-2:0], 1'b0};
        end else begin
            start_bit_d  = frame_word_d[0];
            start_rest_d = {1'b0, frame_word_d[bitcount-1:1]};
            next_bit_d   = shift_q[0];
            next_rest_d  = {1'b0, shift_q[bitcount-1:1]};
        end

        cnt_inc_d  = cnt_q + CW'(1);
        last_bit_d = (cnt_inc_d == CW'(bitcount));
    end

    // Pin synchronizers; reset to the active ss level so ss held active through reset
    // does not look like a fresh assertion afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            ss_s1_q   <= SS_ACT;
            ss_s2_q   <= SS_ACT;
            ss_s3_q   <= SS_ACT;
            sclk_s1_q <= SCLK_IDLE;
            sclk_s2_q <= SCLK_IDLE;
            sclk_s3_q <= SCLK_IDLE;
        end else begin
            ss_s1_q   <= ss;
            ss_s2_q   <= ss_s1_q;
            ss_s3_q   <= ss_s2_q;
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
        end
    end

    // Frame FSM with holding register, shifter, bit counter and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            ready_q    <= 1'b1;
            shift_q    <= '0;
            cnt_q      <= '0;
            sdo_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            underrun_q <= 1'b0;

            // Staging: last write wins; overridden below when a frame consumes the word.
            if (load) begin
                hold_q  <= data;
                ready_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (ss_start_d) begin
                        if (PHASE1) begin
                            shift_q <= frame_word_d;
                            sdo_q   <= 1'b0;
                        end else begin
                            shift_q <= start_rest_d;
                            sdo_q   <= start_bit_d;
                        end
                        underrun_q <= ready_q && !load;
                        hold_q     <= '0;
                        ready_q    <= 1'b1;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ACTIVE;
                    end
                end

                ST_ACTIVE: begin
                    if (!ss_act_d) begin
                        // Master gave up early: drop the word, no completion pulse.
                        busy_q  <= 1'b0;
                        sdo_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (shift_edge_d) begin
                        sdo_q   <= next_bit_d;
                        shift_q <= next_rest_d;
                    end else if (count_edge_d) begin
                        if (last_bit_d) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            sdo_q   <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= ST_WAIT_SS;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
                end

                ST_WAIT_SS: begin
                    // Extra sclk edges are ignored until the master releases ss.
                    if (!ss_act_d) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    sdo_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_TRANSMITTER_TRISTATE_EN
    // Release the shared MISO line whenever this slave is not selected.
    assign sdo = ss_act_d ? sdo_q : 1'bz;
`else
    assign sdo = sdo_q;
`endif

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_transmitter.sv
// Bench for spi_transmitter: three instances (default mode, LSB-first, phase 0 / idle-high sclk)
// driven by a behavioural SPI master; received bits are compared to a word-level model
// of the holding register and wire bit order.
module tb_spi_transmitter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] ss;
    logic [2:0] sclk;
    logic [2:0] load;
    logic [7:0] data [3];
    logic [2:0] sdo, busy, done, underrun, ready;

    int n_vec = 0;
    int n_err = 0;

    int done_cnt [3];
    int und_cnt  [3];

    // Model of each instance's holding register
    logic [7:0] m_hold [3];
    bit         m_full [3];

    always #5 clock = ~clock;

    spi_transmitter u_def (
        .clock(clock), .reset(reset), .data(data[0]), .load(load[0]), .ready(ready[0]),
        .ss(ss[0]), .sclk(sclk[0]), .sdo(sdo[0]), .busy(busy[0]), .done(done[0]),
        .underrun(underrun[0])
    );

    spi_transmitter #(.msb_first(0)) u_lsb (
        .clock(clock), .reset(reset), .data(data[1]), .load(load[1]), .ready(ready[1]),
        .ss(ss[1]), .sclk(sclk[1]), .sdo(sdo[1]), .busy(busy[1]), .done(done[1]),
        .underrun(underrun[1])
    );

    spi_transmitter #(.sclk_polarity(1), .sclk_phase(0)) u_p0 (
        .clock(clock), .reset(reset), .data(data[2]), .load(load[2]), .ready(ready[2]),
        .ss(ss[2]), .sclk(sclk[2]), .sdo(sdo[2]), .busy(busy[2]), .done(done[2]),
        .underrun(underrun[2])
    );

    // Pulse counters, sampled away from the active edge
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) done_cnt[i]++;
            if (underrun[i] === 1'b1) und_cnt[i]++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic idle_lvl(int idx);
        return (idx == 2) ? 1'b1 : 1'b0;
    endfunction

    function automatic bit is_ph1(int idx);
        return idx != 2;
    endfunction

    function automatic bit is_msbf(int idx);
        return idx != 1;
    endfunction

    // Bit k on the wire (k = 0 is sent first)
    function automatic logic [7:0] wire_seq(logic [7:0] w, bit msbf);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = msbf ? w[7-k] : w[k];
        return r;
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_load(input int idx, input logic [7:0] val);
        data[idx] = val;
        load[idx] = 1'b1;
        tick(1);
        load[idx] = 1'b0;
        m_hold[idx] = val;
        m_full[idx] = 1'b1;
    endtask

    // Behavioural master: 16-clock sclk period, samples on the edge the mode dictates.
    task automatic run_frame(input int idx, input int nbits, input bit bypass,
                             input logic [7:0] bw, output logic [7:0] seq,
                             output logic [7:0] tx, output bit exp_und);
        tx      = bypass ? bw : (m_full[idx] ? m_hold[idx] : 8'h00);
        exp_und = !bypass && !m_full[idx];
        m_full[idx] = 1'b0;
        seq = 8'h00;
        ss[idx] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            if (bypass && c == 1) begin
                data[idx] = bw;
                load[idx] = 1'b1;
            end
            if (bypass && c == 2) load[idx] = 1'b0;
        end
        if (is_ph1(idx)) begin
            n_vec++;
            if (sdo[idx] !== 1'b0) begin
                n_err++;
                $display("FAIL sdo_before_first_edge[%0d]: got %b expected 0", idx, sdo[idx]);
            end
        end
        for (int b = 0; b < nbits; b++) begin
            sclk[idx] = ~idle_lvl(idx);
            if (!is_ph1(idx)) seq[b] = sdo[idx];
            tick(8);
            sclk[idx] = idle_lvl(idx);
            if (is_ph1(idx)) seq[b] = sdo[idx];
            tick(8);
        end
        tick(4);
        ss[idx] = 1'b0;
        tick(8);
    endtask

    task automatic test_reset;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            n_vec += 5;
            if (sdo[i] !== 1'b0) begin n_err++; $display("FAIL reset_sdo[%0d]: got %b expected 0", i, sdo[i]); end
            if (busy[i] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d]: got %b expected 0", i, busy[i]); end
            if (done[i] !== 1'b0) begin n_err++; $display("FAIL reset_done[%0d]: got %b expected 0", i, done[i]); end
            if (underrun[i] !== 1'b0) begin n_err++; $display("FAIL reset_underrun[%0d]: got %b expected 0", i, underrun[i]); end
            if (ready[i] !== 1'b1) begin n_err++; $display("FAIL reset_ready[%0d]: got %b expected 1", i, ready[i]); end
        end
        reset = 1'b0;
        tick(4);
    endtask

    // Full frame on one instance with the usual checks on data and pulses
    task automatic test_frame(input string name, input int idx, input bit bypass,
                              input logic [7:0] bw);
        logic [7:0] seq, tx, exp;
        bit         eu;
        int         d0, u0;
        d0 = done_cnt[idx];
        u0 = und_cnt[idx];
        run_frame(idx, 8, bypass, bw, seq, tx, eu);
        exp = wire_seq(tx, is_msbf(idx));
        n_vec += 5;
        if (seq !== exp) begin n_err++; $display("FAIL %s_bits[%0d]: got %b expected %b", name, idx, seq, exp); end
        if (done_cnt[idx] - d0 != 1) begin n_err++; $display("FAIL %s_done[%0d]: got %0d pulses expected 1", name, idx, done_cnt[idx] - d0); end
        if (und_cnt[idx] - u0 != int'(eu)) begin n_err++; $display("FAIL %s_underrun[%0d]: got %0d expected %0d", name, idx, und_cnt[idx] - u0, eu); end
        if (ready[idx] !== 1'b1) begin n_err++; $display("FAIL %s_ready[%0d]: got %b expected 1", name, idx, ready[idx]); end
        if (busy[idx] !== 1'b0) begin n_err++; $display("FAIL %s_busy[%0d]: got %b expected 0", name, idx, busy[idx]); end
    endtask

    task automatic test_basic;
        do_load(0, 8'hA5);
        n_vec++;
        if (ready[0] !== 1'b0) begin n_err++; $display("FAIL basic_ready_after_load: got %b expected 0", ready[0]); end
        test_frame("basic", 0, 1'b0, 8'h00);
    endtask

    task automatic test_lsb_first;
        do_load(1, 8'h01);
        test_frame("lsb", 1, 1'b0, 8'h00);
    endtask

    task automatic test_underrun;
        test_frame("underrun", 0, 1'b0, 8'h00);
    endtask

    task automatic test_abort;
        logic [7:0] seq, tx;
        bit         eu;
        int         d0;
        do_load(0, 8'($urandom));
        d0 = done_cnt[0];
        run_frame(0, 4, 1'b0, 8'h00, seq, tx, eu);
        n_vec += 2;
        if (done_cnt[0] != d0) begin n_err++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt[0] - d0); end
        if (busy[0] !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy[0]); end
        do_load(0, 8'h3C);
        test_frame("after_abort", 0, 1'b0, 8'h00);
    endtask

    task automatic test_phase0;
        do_load(2, 8'hC3);
        test_frame("phase0", 2, 1'b0, 8'h00);
    endtask

    task automatic test_reset_midframe;
        int d0, u0;
        do_load(0, 8'hFF);
        ss[0] = 1'b1;
        tick(8);
        sclk[0] = ~idle_lvl(0);
        tick(8);
        n_vec++;
        if (sdo[0] !== 1'b1) begin n_err++; $display("FAIL midframe_sdo_before_reset: got %b expected 1", sdo[0]); end
        do_load(0, 8'h5A);
        reset = 1'b1;
        tick(1);
        n_vec += 4;
        if (sdo[0] !== 1'b0) begin n_err++; $display("FAIL midreset_sdo: got %b expected 0", sdo[0]); end
        if (busy[0] !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b expected 0", busy[0]); end
        if (ready[0] !== 1'b1) begin n_err++; $display("FAIL midreset_ready: got %b expected 1", ready[0]); end
        if (done[0] !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b expected 0", done[0]); end
        sclk[0] = idle_lvl(0);
        m_full[0] = 1'b0;
        tick(2);
        reset = 1'b0;
        d0 = done_cnt[0];
        u0 = und_cnt[0];
        tick(8);
        for (int k = 0; k < 3; k++) begin
            sclk[0] = ~idle_lvl(0);
            tick(8);
            sclk[0] = idle_lvl(0);
            tick(8);
        end
        n_vec += 3;
        if (busy[0] !== 1'b0) begin n_err++; $display("FAIL held_ss_busy: got %b expected 0", busy[0]); end
        if (sdo[0] !== 1'b0) begin n_err++; $display("FAIL held_ss_sdo: got %b expected 0", sdo[0]); end
        if ((done_cnt[0] - d0) + (und_cnt[0] - u0) != 0) begin
            n_err++;
            $display("FAIL held_ss_pulses: got %0d done %0d underrun expected 0 0", done_cnt[0] - d0, und_cnt[0] - u0);
        end
        ss[0] = 1'b0;
        tick(8);
        do_load(0, 8'h96);
        test_frame("after_reset", 0, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back;
        do_load(0, 8'h11);
        do_load(0, 8'h22);
        test_frame("overwrite", 0, 1'b0, 8'h00);
        test_frame("bypass", 0, 1'b1, 8'($urandom));
        do_load(2, 8'h0F);
        test_frame("bypass_full", 2, 1'b1, 8'hE7);
    endtask

    task automatic test_random;
        for (int n = 0; n < 8; n++) begin
            int idx;
            idx = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                test_frame("rand_bypass", idx, 1'b1, 8'($urandom));
            end else begin
                do_load(idx, 8'($urandom));
                test_frame("rand", idx, 1'b0, 8'h00);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            ss[i]       = 1'b0;
            sclk[i]     = idle_lvl(i);
            load[i]     = 1'b0;
            data[i]     = 8'h00;
            m_hold[i]   = 8'h00;
            m_full[i]   = 1'b0;
            done_cnt[i] = 0;
            und_cnt[i]  = 0;
        end
        test_reset();
        test_basic();
        test_lsb_first();
        test_underrun();
        test_abort();
        test_phase0();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
